pcie_msg_rx_filter: RTL and testbench

PCIE_MSG_RX_FILTER -- requirements
Module: pcie_msg_rx_filter

---
 rtl/pcie_msg_rx_filter.sv | 176 +++++++++++++++++
 tb/tb_pcie_msg_rx_filter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msg_rx_filter.sv
// PCIe message RX filter: forwards message TLPs to a small FIFO,
// drops all other TLPs, and flags length/framing errors.
module pcie_msg_rx_filter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] in_data,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic         in_eop,
  output logic         in_ready,
  output logic [255:0] rx_tlp_data,
  output logic         rx_tlp_valid,
  output logic         rx_tlp_sop,
  output logic         rx_tlp_eop,
  input  logic         rx_tlp_ready,
  output logic         err_len,
  output logic         err_proto,
  output logic [15:0]  msg_cnt,
  output logic [15:0]  drop_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  logic [15:0]   msg_cnt_q, msg_cnt_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          err_len_q, err_len_d;
  logic          err_proto_q, err_proto_d;
  logic [257:0]  mem_q [FIFO_DEPTH];

  logic          full, empty, acc, pop;
  logic          push, push_ok, push_sop, push_eop;
  logic          msg_inc, drop_inc, is_msg;
  logic [10:0]   plen, bsum;
  logic [7:0]    beats;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = (wr_q == rd_q);

  // Drop state sinks beats regardless of FIFO space
  assign in_ready = ~rst & ((state_q == DROP) | ~full);
  assign acc      = in_valid & in_ready;
  assign pop      = ~empty & rx_tlp_ready;
  assign push_ok  = push & ~full;

  // Header decode; Length 0 encodes 1024 DW
  assign is_msg = (in_data[28:27] == 2'b10);
  assign plen   = !in_data[30] ? 11'd0 :
                  (in_data[9:0] == 10'd0) ? 11'd1024 :
                  {1'b0, in_data[9:0]};
  assign bsum   = 11'd11 + plen;
  assign beats  = bsum[10:3];

  // Framing FSM: decides push/discard, counter and error pulses
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_sop  = 1'b0;
    push_eop  = in_eop;
    err_len_d   = 1'b0;
    err_proto_d = 1'b0;
    msg_inc   = 1'b0;
    drop_inc  = 1'b0;
    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (!in_sop) begin
            err_proto_d = 1'b1;
          end else if (is_msg) begin
            push     = 1'b1;
            push_sop = 1'b1;
            msg_inc  = 1'b1;
            if (beats == 8'd1) begin
              if (!in_eop) begin
                push_eop  = 1'b1;
                err_len_d = 1'b1;
                state_d   = DROP;
              end
            end else begin
              cnt_d = beats - 8'd1;
              if (in_eop) err_len_d = 1'b1;
              else        state_d   = PASS;
            end
          end else begin
            drop_inc = 1'b1;
            if (!in_eop) state_d = DROP;
          end
        end
        PASS: begin
          push        = 1'b1;
          err_proto_d = in_sop;
          cnt_d       = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            if (!in_eop) begin
              push_eop  = 1'b1;
              err_len_d = 1'b1;
              state_d   = DROP;
            end else begin
              state_d = IDLE;
            end
          end else if (in_eop) begin
            err_len_d = 1'b1;
            state_d   = IDLE;
          end
        end
        DROP: begin
          err_proto_d = in_sop;
          if (in_eop) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pointer and saturating counter next-state
  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push_ok};
    rd_d = rd_q + {{AW{1'b0}}, pop};
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (msg_inc && msg_cnt_q != 16'hFFFF)
      msg_cnt_d = msg_cnt_q + 16'd1;
    if (drop_inc && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      wr_q        <= '0;
      rd_q        <= '0;
      msg_cnt_q   <= 16'd0;
      drop_cnt_q  <= 16'd0;
      err_len_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      msg_cnt_q   <= msg_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_len_q   <= err_len_d;
      err_proto_q <= err_proto_d;
    end
  end

  // FIFO storage, entry = {sop, eop, data}
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_q[AW-1:0]] <= {push_sop, push_eop, in_data};
  end

  assign rx_tlp_valid = ~empty;
  assign {rx_tlp_sop, rx_tlp_eop, rx_tlp_data} = mem_q[rd_q[AW-1:0]];
  assign err_len   = err_len_q;
  assign err_proto = err_proto_q;
  assign msg_cnt   = msg_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pcie_msg_rx_filter.sv
// Directed bench for pcie_msg_rx_filter: forwarding, dropping,
// backpressure, length/framing errors and mid-packet reset.
module tb_pcie_msg_rx_filter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sop = 1'b0;
  logic         in_eop = 1'b0;
  logic         in_ready;
  logic [255:0] rx_tlp_data;
  logic         rx_tlp_valid;
  logic         rx_tlp_sop;
  logic         rx_tlp_eop;
  logic         rx_tlp_ready = 1'b0;
  logic         err_len;
  logic         err_proto;
  logic [15:0]  msg_cnt;
  logic [15:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] got_q[$];

  pcie_msg_rx_filter #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .rx_tlp_data(rx_tlp_data), .rx_tlp_valid(rx_tlp_valid),
    .rx_tlp_sop(rx_tlp_sop), .rx_tlp_eop(rx_tlp_eop),
    .rx_tlp_ready(rx_tlp_ready),
    .err_len(err_len), .err_proto(err_proto),
    .msg_cnt(msg_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst && rx_tlp_valid && rx_tlp_ready)
      got_q.push_back(rx_tlp_data[255:240]);

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] hdr(input logic [2:0] fmt,
                                       input logic [4:0] typ,
                                       input logic [9:0] len,
                                       input logic [15:0] tag);
    logic [255:0] d;
    d = '0;
    d[31:29]   = fmt;
    d[28:24]   = typ;
    d[9:0]     = len;
    d[255:240] = tag;
    return d;
  endfunction

  function automatic logic [255:0] pay(input logic [15:0] tag);
    logic [255:0] d;
    d = {8{32'h5A5A_0000}};
    d[255:240] = tag;
    return d;
  endfunction

  task automatic send(input logic [255:0] d,
                      input logic s, input logic e);
    logic ok;
    @(negedge clk);
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk);
      if (in_ready) ok = 1'b1;
    end
    check("accept", ok, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", rx_tlp_valid, 0);
    check("rst_msg_cnt", msg_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_errs", {err_len, err_proto}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // single-beat Msg
    rx_tlp_ready = 1'b1;
    send(hdr(3'b001, 5'b10000, 10'd0, 16'hA001), 1, 1);
    check("m1_valid", rx_tlp_valid, 1);
    check("m1_sop_eop", {rx_tlp_sop, rx_tlp_eop}, 2'b11);
    check("m1_data", rx_tlp_data, hdr(3'b001, 5'b10000, 10'd0, 16'hA001));
    check("m1_cnt", msg_cnt, 1);
    check("m1_err", {err_len, err_proto}, 0);

    // two-beat MsgD, Length=12
    send(hdr(3'b011, 5'b10000, 10'd12, 16'hA002), 1, 0);
    check("m2b1_sop_eop", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b110);
    send(pay(16'hA003), 0, 1);
    check("m2b2_sop_eop", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b101);
    check("m2b2_data", rx_tlp_data, pay(16'hA003));
    check("m2_err", {err_len, err_proto}, 0);
    check("m2_cnt", msg_cnt, 2);

    // three-beat MWr is dropped
    send(hdr(3'b011, 5'b00000, 10'd16, 16'hB001), 1, 0);
    check("mwr_b1_valid", rx_tlp_valid, 0);
    check("mwr_b1_ready", in_ready, 1);
    send(pay(16'hB002), 0, 0);
    check("mwr_b2_valid", rx_tlp_valid, 0);
    send(pay(16'hB003), 0, 1);
    check("mwr_b3_valid", rx_tlp_valid, 0);
    check("mwr_drop_cnt", drop_cnt, 1);
    check("mwr_msg_cnt", msg_cnt, 2);
    check("mwr_err", {err_len, err_proto}, 0);

    // backpressure: six one-beat messages into depth 4
    @(negedge clk);
    got_q.delete();
    rx_tlp_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      send(hdr(3'b001, 5'b10010, 10'd0, 16'hC000 + 16'(i)), 1, 1);
    check("bp_full_ready", in_ready, 0);
    check("bp_head", rx_tlp_data[255:240], 16'hC001);
    fork
      begin
        repeat (2) begin
          @(negedge clk);
          check("bp_hold_data", rx_tlp_data[255:240], 16'hC001);
          check("bp_hold_flags", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b111);
          check("bp_hold_ready", in_ready, 0);
        end
        rx_tlp_ready = 1'b1;
      end
      begin
        send(hdr(3'b001, 5'b10010, 10'd0, 16'hC005), 1, 1);
        send(hdr(3'b001, 5'b10010, 10'd0, 16'hC006), 1, 1);
      end
    join
    repeat (8) @(negedge clk);
    check("bp_count", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++)
      check("bp_order", got_q[i], 16'hC001 + 16'(i));
    check("bp_msg_cnt", msg_cnt, 8);

    // MsgD Length=4 with EOP late: forced EOP then drop
    got_q.delete();
    send(hdr(3'b011, 5'b10000, 10'd4, 16'hD001), 1, 0);
    check("late_b1_eop", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b111);
    check("late_b1_errlen", err_len, 1);
    send(pay(16'hD002), 0, 0);
    check("late_b2_errlen", err_len, 0);
    check("late_b2_valid", rx_tlp_valid, 0);
    send(pay(16'hD003), 0, 1);
    check("late_b3_valid", rx_tlp_valid, 0);
    check("late_errs", {err_len, err_proto}, 0);
    check("late_fwd", got_q.size(), 1);

    // stray payload in IDLE, then SOP inside a packet
    send(pay(16'hE000), 0, 0);
    check("stray_proto", err_proto, 1);
    check("stray_valid", rx_tlp_valid, 0);
    send(hdr(3'b011, 5'b10000, 10'd12, 16'hE001), 1, 0);
    check("midsop_b1_err", err_proto, 0);
    send(pay(16'hE002), 1, 1);
    check("midsop_proto", err_proto, 1);
    check("midsop_len", err_len, 0);
    check("midsop_flags", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b101);

    // early EOP on a two-beat MsgD
    send(hdr(3'b011, 5'b10000, 10'd12, 16'hE101), 1, 1);
    check("early_len", err_len, 1);
    check("early_flags", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b111);

    // Length 0 means 1024 DW: second-beat EOP is early
    send(hdr(3'b011, 5'b10000, 10'd0, 16'hE201), 1, 0);
    check("len0_b1_flags", {rx_tlp_sop, rx_tlp_eop, err_len}, 3'b100);
    send(pay(16'hE202), 0, 1);
    check("len0_b2_len", err_len, 1);
    check("len0_b2_eop", rx_tlp_eop, 1);
    check("pre_rst_msg_cnt", msg_cnt, 12);
    check("pre_rst_drop_cnt", drop_cnt, 1);

    // reset during second beat of a two-beat MsgD
    rx_tlp_ready = 1'b0;
    send(hdr(3'b011, 5'b10000, 10'd12, 16'hF001), 1, 0);
    check("mr_b1_valid", rx_tlp_valid, 1);
    @(negedge clk);
    in_data = pay(16'hF002); in_sop = 1'b0; in_eop = 1'b1;
    in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    check("mr_valid", rx_tlp_valid, 0);
    check("mr_cnts", {msg_cnt, drop_cnt}, 0);
    check("mr_errs", {err_len, err_proto}, 0);
    check("mr_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0; in_eop = 1'b0;
    @(negedge clk);
    check("mr_post_ready", in_ready, 1);
    check("mr_post_valid", rx_tlp_valid, 0);
    rx_tlp_ready = 1'b1;
    send(hdr(3'b001, 5'b10000, 10'd0, 16'hF101), 1, 1);
    check("mr_new_flags", {rx_tlp_valid, rx_tlp_sop, rx_tlp_eop}, 3'b111);
    check("mr_new_tag", rx_tlp_data[255:240], 16'hF101);
    check("mr_new_errs", {err_len, err_proto}, 0);
    check("mr_new_cnt", msg_cnt, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
